conv_cfg_sequencer: RTL and testbench

//  Sequences register writes into the LTC2195 ADC and AD9783 DAC driver command ports (cmd_trig/addr/data).
//  - After reset: plays a boot table of N_BOOT entries from an external ROM.
//  - Then grants single host commands, one at a time.

---
 rtl/conv_cfg_sequencer.sv | 156 +++++++++++++++
 tb/tb_conv_cfg_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_cfg_sequencer.sv
// Single command master for the LTC2195 ADC and AD9783 DAC drivers: replays a boot
// table from an external ROM after reset, then serves one host command at a time.
module conv_cfg_sequencer #(
    parameter int N_BOOT      = 8,
    parameter int WAIT_CYCLES = 1024,
    parameter int TBL_AW      = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [32:0]       tbl_data,
    input  logic              host_req,
    input  logic              host_target,
    input  logic [15:0]       host_addr,
    input  logic [15:0]       host_data,
    output logic              host_ack,
    output logic [15:0]       host_rdata,
    output logic              adc_cmd_trig,
    output logic [15:0]       adc_cmd_addr,
    output logic [15:0]       adc_cmd_data,
    output logic              dac_cmd_trig,
    output logic [15:0]       dac_cmd_addr,
    output logic [15:0]       dac_cmd_data,
    input  logic [15:0]       dac_rdata_in,
    output logic              boot_done,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_BFETCH, S_BISSUE, S_BWAIT, S_READY, S_HISSUE, S_HWAIT
    } state_t;

    localparam logic [15:0]       WAIT_LOAD = 16'(WAIT_CYCLES - 1);
    localparam logic [TBL_AW-1:0] LAST_IDX  = TBL_AW'(N_BOOT - 1);

    state_t            state_q;
    logic [TBL_AW-1:0] idx_q;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic              tgt_q;
    logic [15:0]       haddr_q;
    logic [15:0]       hdata_q;
    logic              adc_trig_q, dac_trig_q;
    logic [15:0]       adc_addr_q, adc_data_q;
    logic [15:0]       dac_addr_q, dac_data_q;
    logic              ack_q;
    logic [15:0]       rdata_q;
    logic              boot_done_q;

    logic              issue_en;
    logic              iss_tgt;
    logic [15:0]       iss_addr;
    logic [15:0]       iss_data;
    logic              wait_done;

    // Boot issues straight from the ROM word; host issues from the latched request.
    always_comb begin
        issue_en = (state_q == S_BISSUE) || (state_q == S_HISSUE);
        iss_tgt  = tgt_q;
        iss_addr = haddr_q;
        iss_data = hdata_q;
        if (state_q == S_BISSUE) begin
            iss_tgt  = tbl_data[32];
            iss_addr = tbl_data[31:16];
            iss_data = tbl_data[15:0];
        end
        cnt_d     = cnt_q - 16'd1;
        wait_done = (cnt_q == 16'd1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_BFETCH;
            idx_q       <= '0;
            cnt_q       <= '0;
            tgt_q       <= 1'b0;
            haddr_q     <= '0;
            hdata_q     <= '0;
            adc_trig_q  <= 1'b0;
            dac_trig_q  <= 1'b0;
            adc_addr_q  <= '0;
            adc_data_q  <= '0;
            dac_addr_q  <= '0;
            dac_data_q  <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            boot_done_q <= 1'b0;
        end else begin
            adc_trig_q <= 1'b0;
            dac_trig_q <= 1'b0;
            ack_q      <= 1'b0;

            if (issue_en) begin
                cnt_q <= WAIT_LOAD;
                if (iss_tgt) begin
                    dac_trig_q <= 1'b1;
                    dac_addr_q <= iss_addr;
                    dac_data_q <= iss_data;
                end else begin
                    adc_trig_q <= 1'b1;
                    adc_addr_q <= iss_addr;
                    adc_data_q <= iss_data;
                end
            end

            // The wait ends on the decrement to zero, giving WAIT_CYCLES+1 trig spacing.
            case (state_q)
                S_BFETCH: state_q <= S_BISSUE;
                S_BISSUE: state_q <= S_BWAIT;
                S_BWAIT: begin
                    cnt_q <= cnt_d;
                    if (wait_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= S_READY;
                            boot_done_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_BFETCH;
                        end
                    end
                end
                S_READY: begin
                    if (host_req && !ack_q) begin
                        tgt_q   <= host_target;
                        haddr_q <= host_addr;
                        hdata_q <= host_data;
                        state_q <= S_HISSUE;
                    end
                end
                S_HISSUE: state_q <= S_HWAIT;
                S_HWAIT: begin
                    cnt_q <= cnt_d;
                    if (wait_done) begin
                        ack_q   <= 1'b1;
                        rdata_q <= tgt_q ? dac_rdata_in : 16'h0000;
                        state_q <= S_READY;
                    end
                end
                default: state_q <= S_BFETCH;
            endcase
        end
    end

    assign tbl_addr     = idx_q;
    assign host_ack     = ack_q;
    assign host_rdata   = rdata_q;
    assign adc_cmd_trig = adc_trig_q;
    assign adc_cmd_addr = adc_addr_q;
    assign adc_cmd_data = adc_data_q;
    assign dac_cmd_trig = dac_trig_q;
    assign dac_cmd_addr = dac_addr_q;
    assign dac_cmd_data = dac_data_q;
    assign boot_done    = boot_done_q;
    assign busy         = (state_q != S_READY);

endmodule

// File: tb/tb_conv_cfg_sequencer.sv
// Directed bench for conv_cfg_sequencer: boot replay, host commands, mid-boot reset,
// and a second instance with the shortest wait for tight back-to-back boot entries.
module tb_conv_cfg_sequencer;

    localparam int W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  tbl_addr;
    logic [32:0] tbl_data;
    logic        host_req, host_target;
    logic [15:0] host_addr, host_data;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        adc_cmd_trig, dac_cmd_trig;
    logic [15:0] adc_cmd_addr, adc_cmd_data, dac_cmd_addr, dac_cmd_data;
    logic [15:0] dac_rdata_in;
    logic        boot_done, busy;

    logic        rst2;
    logic [7:0]  tbl_addr2;
    logic [32:0] tbl_data2;
    logic        host_req2, host_target2;
    logic [15:0] host_addr2, host_data2;
    logic        host_ack2;
    logic [15:0] host_rdata2;
    logic        adc_cmd_trig2, dac_cmd_trig2;
    logic [15:0] adc_cmd_addr2, adc_cmd_data2, dac_cmd_addr2, dac_cmd_data2;
    logic [15:0] dac_rdata_in2;
    logic        boot_done2, busy2;

    logic [32:0] rom [0:255];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) tbl_data  <= rom[tbl_addr];
    always @(posedge clk) tbl_data2 <= rom[tbl_addr2];

    conv_cfg_sequencer #(.N_BOOT(3), .WAIT_CYCLES(W), .TBL_AW(8)) u_dut (
        .clk_in(clk), .rst_in(rst), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .host_req(host_req), .host_target(host_target), .host_addr(host_addr),
        .host_data(host_data), .host_ack(host_ack), .host_rdata(host_rdata),
        .adc_cmd_trig(adc_cmd_trig), .adc_cmd_addr(adc_cmd_addr), .adc_cmd_data(adc_cmd_data),
        .dac_cmd_trig(dac_cmd_trig), .dac_cmd_addr(dac_cmd_addr), .dac_cmd_data(dac_cmd_data),
        .dac_rdata_in(dac_rdata_in), .boot_done(boot_done), .busy(busy)
    );

    conv_cfg_sequencer #(.N_BOOT(3), .WAIT_CYCLES(2), .TBL_AW(8)) u_dut2 (
        .clk_in(clk), .rst_in(rst2), .tbl_addr(tbl_addr2), .tbl_data(tbl_data2),
        .host_req(host_req2), .host_target(host_target2), .host_addr(host_addr2),
        .host_data(host_data2), .host_ack(host_ack2), .host_rdata(host_rdata2),
        .adc_cmd_trig(adc_cmd_trig2), .adc_cmd_addr(adc_cmd_addr2), .adc_cmd_data(adc_cmd_data2),
        .dac_cmd_trig(dac_cmd_trig2), .dac_cmd_addr(dac_cmd_addr2), .dac_cmd_data(dac_cmd_data2),
        .dac_rdata_in(dac_rdata_in2), .boot_done(boot_done2), .busy(busy2)
    );

    task automatic tick();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        logic [92:0] obs;
        rst = 1'b1;
        host_req = 1'b1; host_target = 1'b1; host_addr = 16'h0005; host_data = 16'h1234;
        dac_rdata_in = 16'hBEEF;
        repeat (3) tick();
        obs = {tbl_addr, host_ack, host_rdata, adc_cmd_trig, adc_cmd_addr, adc_cmd_data,
               dac_cmd_trig, dac_cmd_addr, dac_cmd_data, boot_done, busy};
        checks++;
        if (obs !== 93'd1) begin
            errors++; $display("[TB] FAIL reset_hold: got %h expected %h", obs, 93'd1);
        end
        rst = 1'b0; cyc = 0;
        tick();
        obs = {tbl_addr, host_ack, host_rdata, adc_cmd_trig, adc_cmd_addr, adc_cmd_data,
               dac_cmd_trig, dac_cmd_addr, dac_cmd_data, boot_done, busy};
        checks++;
        if (obs !== 93'd1) begin
            errors++; $display("[TB] FAIL reset_release: got %h expected %h", obs, 93'd1);
        end
    endtask

    // Expects cyc==1 (one edge after reset release) on entry; leaves at the first READY cycle.
    task automatic test_boot(input string tag);
        logic [32:0] e;
        logic [31:0] ad;
        int expc;
        for (int k = 0; k < 3; k++) begin
            e = rom[k];
            expc = 2 + (W + 1) * k;
            while (!(adc_cmd_trig || dac_cmd_trig) && cyc < expc + 10) tick();
            checks++;
            if (cyc !== expc) begin
                errors++; $display("[TB] FAIL %s_e%0d_time: got %0d expected %0d", tag, k, cyc, expc);
            end
            checks++;
            if ({dac_cmd_trig, adc_cmd_trig} !== (e[32] ? 2'b10 : 2'b01)) begin
                errors++; $display("[TB] FAIL %s_e%0d_target: got %b expected %b", tag, k,
                                   {dac_cmd_trig, adc_cmd_trig}, (e[32] ? 2'b10 : 2'b01));
            end
            ad = e[32] ? {dac_cmd_addr, dac_cmd_data} : {adc_cmd_addr, adc_cmd_data};
            checks++;
            if (ad !== e[31:0]) begin
                errors++; $display("[TB] FAIL %s_e%0d_addrdata: got %h expected %h", tag, k, ad, e[31:0]);
            end
            checks++;
            if ({boot_done, tbl_addr} !== {1'b0, 8'(k)}) begin
                errors++; $display("[TB] FAIL %s_e%0d_idx: got %h expected %h", tag, k,
                                   {boot_done, tbl_addr}, {1'b0, 8'(k)});
            end
            tick();
            checks++;
            if ({dac_cmd_trig, adc_cmd_trig} !== 2'b00) begin
                errors++; $display("[TB] FAIL %s_e%0d_width: got %b expected 00", tag, k,
                                   {dac_cmd_trig, adc_cmd_trig});
            end
        end
        while (!boot_done && cyc < 40) tick();
        checks++;
        if (cyc !== 2 + 2 * (W + 1) + W - 1) begin
            errors++; $display("[TB] FAIL %s_boot_done_time: got %0d expected %0d", tag, cyc,
                               2 + 2 * (W + 1) + W - 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL %s_busy_ready: got %b expected 0", tag, busy);
        end
    endtask

    task automatic test_host_dac();
        int rs, tt;
        rs = cyc;
        while (!(adc_cmd_trig || dac_cmd_trig) && cyc < rs + 10) tick();
        tt = cyc;
        checks++;
        if (cyc !== rs + 2) begin
            errors++; $display("[TB] FAIL hdac_trig_time: got %0d expected %0d", cyc, rs + 2);
        end
        checks++;
        if ({dac_cmd_trig, adc_cmd_trig, dac_cmd_addr, dac_cmd_data} !== {2'b10, 16'h0005, 16'h1234}) begin
            errors++; $display("[TB] FAIL hdac_cmd: got %h expected %h",
                {dac_cmd_trig, adc_cmd_trig, dac_cmd_addr, dac_cmd_data}, {2'b10, 16'h0005, 16'h1234});
        end
        tick();
        while (!host_ack && cyc < tt + W + 5) tick();
        checks++;
        if (cyc !== tt + W - 1) begin
            errors++; $display("[TB] FAIL hdac_ack_time: got %0d expected %0d", cyc, tt + W - 1);
        end
        checks++;
        if (host_rdata !== 16'hBEEF) begin
            errors++; $display("[TB] FAIL hdac_rdata: got %h expected BEEF", host_rdata);
        end
        host_req = 1'b0;
        tick();
        checks++;
        if ({host_ack, host_rdata, busy} !== {1'b0, 16'hBEEF, 1'b0}) begin
            errors++; $display("[TB] FAIL hdac_after_ack: got %h expected %h",
                               {host_ack, host_rdata, busy}, {1'b0, 16'hBEEF, 1'b0});
        end
    endtask

    task automatic test_host_adc();
        int rs, tt;
        host_target = 1'b0; host_addr = 16'h0004; host_data = 16'h00AA; host_req = 1'b1;
        rs = cyc;
        while (!(adc_cmd_trig || dac_cmd_trig) && cyc < rs + 10) tick();
        tt = cyc;
        host_req = 1'b0;
        checks++;
        if (cyc !== rs + 2) begin
            errors++; $display("[TB] FAIL hadc_trig_time: got %0d expected %0d", cyc, rs + 2);
        end
        checks++;
        if ({dac_cmd_trig, adc_cmd_trig, adc_cmd_addr, adc_cmd_data} !== {2'b01, 16'h0004, 16'h00AA}) begin
            errors++; $display("[TB] FAIL hadc_cmd: got %h expected %h",
                {dac_cmd_trig, adc_cmd_trig, adc_cmd_addr, adc_cmd_data}, {2'b01, 16'h0004, 16'h00AA});
        end
        tick();
        while (!host_ack && cyc < tt + W + 5) tick();
        checks++;
        if (cyc !== tt + W - 1) begin
            errors++; $display("[TB] FAIL hadc_ack_time: got %0d expected %0d", cyc, tt + W - 1);
        end
        checks++;
        if ({host_rdata, dac_cmd_addr, dac_cmd_data} !== {16'h0000, 16'h0005, 16'h1234}) begin
            errors++; $display("[TB] FAIL hadc_rdata_dac_hold: got %h expected %h",
                {host_rdata, dac_cmd_addr, dac_cmd_data}, {16'h0000, 16'h0005, 16'h1234});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int s, nt, na, bad;
        int tc [4];
        int ac [4];
        nt = 0; na = 0; bad = 0;
        host_target = 1'b1; host_addr = 16'h0007; host_data = 16'h5555; host_req = 1'b1;
        s = cyc;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (adc_cmd_trig) bad++;
            if (dac_cmd_trig) begin
                if (nt < 4) tc[nt] = cyc;
                nt++;
            end
            if (host_ack) begin
                if (na < 4) ac[na] = cyc;
                na++;
                if (na == 2) host_req = 1'b0;
            end
        end
        checks++;
        if ({nt, na, bad} !== {32'd2, 32'd2, 32'd0}) begin
            errors++; $display("[TB] FAIL b2b_counts: got trigs %0d acks %0d adc %0d expected 2 2 0",
                               nt, na, bad);
        end else begin
            checks++;
            if ({tc[0], ac[0], tc[1], ac[1]} !== {s + 2, s + 2 + W - 1, s + W + 4, s + 2 * W + 3}) begin
                errors++; $display("[TB] FAIL b2b_timing: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                    tc[0], ac[0], tc[1], ac[1], s + 2, s + W + 1, s + W + 4, s + 2 * W + 3);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [92:0] obs;
        host_req = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; cyc = 0;
        while (!dac_cmd_trig && cyc < 20) tick();
        checks++;
        if (cyc !== 2 + W + 1) begin
            errors++; $display("[TB] FAIL mid_e1_time: got %0d expected %0d", cyc, 2 + W + 1);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        obs = {tbl_addr, host_ack, host_rdata, adc_cmd_trig, adc_cmd_addr, adc_cmd_data,
               dac_cmd_trig, dac_cmd_addr, dac_cmd_data, boot_done, busy};
        checks++;
        if (obs !== 93'd1) begin
            errors++; $display("[TB] FAIL mid_reset_vals: got %h expected %h", obs, 93'd1);
        end
        tick();
        rst = 1'b0; cyc = 0;
        tick();
        test_boot("replay");
    endtask

    task automatic test_short_wait();
        int base, n, wide, bd;
        logic prev;
        int tc [4];
        n = 0; wide = 0; bd = -1; prev = 1'b0;
        rst2 = 1'b0;
        base = cyc;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (adc_cmd_trig2 || dac_cmd_trig2) begin
                if (prev) wide++;
                if (n < 4) tc[n] = cyc - base;
                n++;
            end
            prev = adc_cmd_trig2 || dac_cmd_trig2;
            if (boot_done2 && bd < 0) bd = cyc - base;
        end
        checks++;
        if ({n, wide, bd} !== {32'd3, 32'd0, 32'd9}) begin
            errors++; $display("[TB] FAIL short_counts: got n %0d wide %0d done %0d expected 3 0 9",
                               n, wide, bd);
        end else begin
            checks++;
            if ({tc[0], tc[1], tc[2]} !== {32'd2, 32'd5, 32'd8}) begin
                errors++; $display("[TB] FAIL short_spacing: got %0d %0d %0d expected 2 5 8",
                                   tc[0], tc[1], tc[2]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 33'h0;
        rom[0] = {1'b0, 16'h0001, 16'h0080};
        rom[1] = {1'b1, 16'h0002, 16'h0011};
        rom[2] = {1'b0, 16'h0003, 16'h0004};
        rst2 = 1'b1; host_req2 = 1'b0; host_target2 = 1'b0;
        host_addr2 = 16'h0; host_data2 = 16'h0; dac_rdata_in2 = 16'h0;
        test_reset();
        test_boot("boot");
        test_host_dac();
        test_host_adc();
        test_back_to_back();
        test_mid_reset();
        test_short_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
